// File: rtl/sddr_phy_leveler.sv
// rtl/sddr_phy_leveler.sv - per-lane IDELAY tap search sequencer for DDR3 leveling
//
// Purpose: steps a shared delay tap across all byte lanes, samples a per-lane
// feedback bit at each tap, and locks each lane at the first tap where the
// feedback is stable at the target level after having been stable opposite.
//
// Ports:
//   in_ddr_clock_i      controller clock (rising edge)
//   in_phy_reset_i      synchronous active-high reset
//   ctl_level_start_i   start request, honoured in IDLE/DONE
//   ctl_level_abort_i   return to IDLE from any state, clears results
//   ctl_level_target_i  target feedback level, latched at start
//   ctl_level_busy_o    search in progress
//   ctl_level_done_o    search finished, results valid
//   ctl_level_fail_o    per-lane no-edge-found flag
//   ctl_level_tap_o     per-lane locked tap, lane n at [n*TAP_BITS +: TAP_BITS]
//   ctl_write_level_o   leveling mode enable for DQ/DQS (mirrors busy)
//   phy_level_sample_i  per-lane synchronised feedback bit
//   phy_delay_ld_o      load tap 0 into every lane delay
//   phy_delay_ce_o      per-lane tap increment enable
//   phy_delay_inc_o     increment direction, tied high
module sddr_phy_leveler #(
    parameter int LANES         = 2,
    parameter int TAP_BITS      = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 8
) (
    input  logic                      in_ddr_clock_i,
    input  logic                      in_phy_reset_i,
    input  logic                      ctl_level_start_i,
    input  logic                      ctl_level_abort_i,
    input  logic                      ctl_level_target_i,
    output logic                      ctl_level_busy_o,
    output logic                      ctl_level_done_o,
    output logic [LANES-1:0]          ctl_level_fail_o,
    output logic [LANES*TAP_BITS-1:0] ctl_level_tap_o,
    output logic                      ctl_write_level_o,
    input  logic [LANES-1:0]          phy_level_sample_i,
    output logic                      phy_delay_ld_o,
    output logic [LANES-1:0]          phy_delay_ce_o,
    output logic                      phy_delay_inc_o
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [TAP_BITS-1:0] TAP_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_STEP,
        S_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [TAP_BITS-1:0]                tap_q, tap_d;
    logic                               target_q, target_d;
    logic [LANES-1:0]                   locked_q, locked_d;
    logic [LANES-1:0]                   seen_q, seen_d;
    logic [LANES-1:0]                   fail_q, fail_d;
    logic [LANES-1:0]                   ones_q, ones_d;
    logic [LANES-1:0]                   zeros_q, zeros_d;
    logic [LANES-1:0][TAP_BITS-1:0]     tap_out_q, tap_out_d;

    logic             settle_last;
    logic             sample_last;
    logic [LANES-1:0] stable_tgt;
    logic [LANES-1:0] stable_opp;
    logic             all_resolved;

    assign settle_last  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    assign sample_last  = (cnt_q == CNT_W'(SAMPLES - 1));
    assign stable_tgt   = target_q ? ones_q  : zeros_q;
    assign stable_opp   = target_q ? zeros_q : ones_q;
    // Uses this cycle's lock decisions so a lane locking in EVAL counts now.
    assign all_resolved = &(locked_d | fail_q);

    // State register
    always_ff @(posedge in_ddr_clock_i) begin
        if (in_phy_reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (ctl_level_abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (ctl_level_start_i) state_d = S_LOAD;
                S_LOAD:         state_d = S_SETTLE;
                S_SETTLE:       if (settle_last) state_d = S_SAMPLE;
                S_SAMPLE:       if (sample_last) state_d = S_EVAL;
                S_EVAL:         state_d = (all_resolved || tap_q == TAP_MAX) ? S_DONE : S_STEP;
                S_STEP:         state_d = S_SETTLE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        ctl_level_busy_o = (state_q == S_LOAD) || (state_q == S_SETTLE) ||
                           (state_q == S_SAMPLE) || (state_q == S_EVAL) ||
                           (state_q == S_STEP);
        ctl_level_done_o = (state_q == S_DONE);
        phy_delay_ld_o   = (state_q == S_LOAD);
        phy_delay_ce_o   = (state_q == S_STEP) ? ~locked_q : '0;
    end

    assign ctl_write_level_o = ctl_level_busy_o;
    assign phy_delay_inc_o   = 1'b1;
    assign ctl_level_fail_o  = fail_q;
    assign ctl_level_tap_o   = tap_out_q;

    // Datapath next-state
    always_comb begin
        cnt_d     = '0;
        tap_d     = tap_q;
        target_d  = target_q;
        locked_d  = locked_q;
        seen_d    = seen_q;
        fail_d    = fail_q;
        ones_d    = ones_q;
        zeros_d   = zeros_q;
        tap_out_d = tap_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (ctl_level_start_i) begin
                    target_d  = ctl_level_target_i;
                    locked_d  = '0;
                    seen_d    = '0;
                    fail_d    = '0;
                    tap_out_d = '0;
                end
            end
            S_LOAD: tap_d = '0;
            S_SETTLE: begin
                if (!settle_last) cnt_d = cnt_q + 1'b1;
            end
            S_SAMPLE: begin
                if (!sample_last) cnt_d = cnt_q + 1'b1;
                // First sample cycle reseeds the accumulators.
                if (cnt_q == '0) begin
                    ones_d  = phy_level_sample_i;
                    zeros_d = ~phy_level_sample_i;
                end else begin
                    ones_d  = ones_q & phy_level_sample_i;
                    zeros_d = zeros_q & ~phy_level_sample_i;
                end
            end
            S_EVAL: begin
                for (int n = 0; n < LANES; n++) begin
                    if (!locked_q[n] && !fail_q[n]) begin
                        if (stable_tgt[n] && seen_q[n]) begin
                            locked_d[n]  = 1'b1;
                            tap_out_d[n] = tap_q;
                        end else if (stable_opp[n]) begin
                            seen_d[n] = 1'b1;
                        end
                    end
                end
                // Lanes that lock at the last tap are excluded from failing.
                if (tap_q == TAP_MAX) fail_d = fail_q | ~locked_d;
            end
            S_STEP: tap_d = tap_q + 1'b1;
            default: ;
        endcase

        if (ctl_level_abort_i) begin
            cnt_d     = '0;
            tap_d     = '0;
            locked_d  = '0;
            seen_d    = '0;
            fail_d    = '0;
            tap_out_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge in_ddr_clock_i) begin
        if (in_phy_reset_i) begin
            cnt_q     <= '0;
            tap_q     <= '0;
            target_q  <= 1'b0;
            locked_q  <= '0;
            seen_q    <= '0;
            fail_q    <= '0;
            ones_q    <= '0;
            zeros_q   <= '0;
            tap_out_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            tap_q     <= tap_d;
            target_q  <= target_d;
            locked_q  <= locked_d;
            seen_q    <= seen_d;
            fail_q    <= fail_d;
            ones_q    <= ones_d;
            zeros_q   <= zeros_d;
            tap_out_q <= tap_out_d;
        end
    end

endmodule

// File: tb/tb_sddr_phy_leveler.sv
// tb/tb_sddr_phy_leveler.sv - self-checking bench for sddr_phy_leveler
module tb_sddr_phy_leveler;

    localparam int LANES    = 2;
    localparam int TAP_BITS = 5;
    localparam int SETTLE   = 16;
    localparam int SAMPLES  = 8;
    localparam int MAXTAP   = (1 << TAP_BITS) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic                      abort;
    logic                      target;
    logic                      busy;
    logic                      done;
    logic [LANES-1:0]          fail;
    logic [LANES*TAP_BITS-1:0] tap_o;
    logic                      wl;
    logic [LANES-1:0]          sample;
    logic                      ld;
    logic [LANES-1:0]          ce;
    logic                      inc;

    sddr_phy_leveler #(
        .LANES(LANES), .TAP_BITS(TAP_BITS), .SETTLE_CYCLES(SETTLE), .SAMPLES(SAMPLES)
    ) dut (
        .in_ddr_clock_i     (clk),
        .in_phy_reset_i     (rst),
        .ctl_level_start_i  (start),
        .ctl_level_abort_i  (abort),
        .ctl_level_target_i (target),
        .ctl_level_busy_o   (busy),
        .ctl_level_done_o   (done),
        .ctl_level_fail_o   (fail),
        .ctl_level_tap_o    (tap_o),
        .ctl_write_level_o  (wl),
        .phy_level_sample_i (sample),
        .phy_delay_ld_o     (ld),
        .phy_delay_ce_o     (ce),
        .phy_delay_inc_o    (inc)
    );

    always #5 clk = ~clk;

    // Delay-line model: each lane's feedback depends on how many CE pulses
    // that lane has received since the last LD.
    int cfg_edge [LANES];
    bit cfg_bef  [LANES];
    bit cfg_aft  [LANES];
    int cfg_tog  [LANES];
    int lane_tap [LANES];
    int ce_cnt   [LANES];
    int ld_cnt;
    bit tog;

    initial begin
        ld_cnt = 0;
        tog    = 1'b0;
        sample = '0;
        for (int n = 0; n < LANES; n++) begin
            lane_tap[n] = 0;
            ce_cnt[n]   = 0;
        end
    end

    always @(negedge clk) begin
        if (ld === 1'b1) begin
            ld_cnt = ld_cnt + 1;
            for (int n = 0; n < LANES; n++) lane_tap[n] = 0;
        end
        for (int n = 0; n < LANES; n++) begin
            if (ce[n] === 1'b1) begin
                lane_tap[n] = lane_tap[n] + 1;
                ce_cnt[n]   = ce_cnt[n] + 1;
            end
        end
        tog = ~tog;
        for (int n = 0; n < LANES; n++) begin
            if (lane_tap[n] == cfg_tog[n])
                sample[n] = tog;
            else
                sample[n] = (lane_tap[n] >= cfg_edge[n]) ? cfg_aft[n] : cfg_bef[n];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: walk the taps from the feedback description.
    int exp_tap  [LANES];
    bit exp_fail [LANES];
    int exp_ce   [LANES];
    int exp_last;
    int exp_lat;

    task automatic ref_model(input bit tgt);
        bit any_fail = 1'b0;
        int maxlock  = 0;
        for (int n = 0; n < LANES; n++) begin
            bit seen = 1'b0;
            int lock = -1;
            for (int t = 0; t <= MAXTAP; t++) begin
                bit lvl;
                if (t == cfg_tog[n]) continue;
                lvl = (t >= cfg_edge[n]) ? cfg_aft[n] : cfg_bef[n];
                if (lvl == tgt && seen) begin
                    lock = t;
                    break;
                end
                if (lvl != tgt) seen = 1'b1;
            end
            exp_fail[n] = (lock < 0);
            exp_tap[n]  = (lock < 0) ? 0 : lock;
            exp_ce[n]   = (lock < 0) ? MAXTAP : lock;
            if (lock < 0) any_fail = 1'b1;
            else if (lock > maxlock) maxlock = lock;
        end
        exp_last = any_fail ? MAXTAP : maxlock;
        exp_lat  = 1 + (exp_last + 1) * (SETTLE + SAMPLES + 1) + exp_last;
    endtask

    int base_ce [LANES];
    int base_ld;

    task automatic snap();
        for (int n = 0; n < LANES; n++) base_ce[n] = ce_cnt[n];
        base_ld = ld_cnt;
    endtask

    // Start a run and wait for done; poke_at re-asserts start mid-run.
    task automatic do_run(input bit tgt, input int poke_at, output int lat);
        int n = 0;
        snap();
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done !== 1'b1 && n < 2000) begin
            start = (n == poke_at);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        lat = n;
    endtask

    task automatic check_result(input string tag, input int lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wl"}, wl, 0);
        chk({tag, "_ld_pulses"}, ld_cnt - base_ld, 1);
        for (int n = 0; n < LANES; n++)
            chk($sformatf("%s_ce%0d", tag, n), ce_cnt[n] - base_ce[n], exp_ce[n]);
    endtask

    typedef struct {
        bit         tgt;
        int         edge0, edge1;
        bit         bef0, bef1, aft0, aft1;
        int         tog0, tog1;
        int         etap0, etap1;
        logic [1:0] efail;
    } vec_t;

    vec_t vecs [5];

    task automatic load_cfg(input vec_t v);
        cfg_edge[0] = v.edge0; cfg_edge[1] = v.edge1;
        cfg_bef[0]  = v.bef0;  cfg_bef[1]  = v.bef1;
        cfg_aft[0]  = v.aft0;  cfg_aft[1]  = v.aft1;
        cfg_tog[0]  = v.tog0;  cfg_tog[1]  = v.tog1;
    endtask

    initial begin
        int   lat;
        vec_t v;

        vecs[0] = '{1'b1, 7, 12, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 7, 12, 2'b00};
        vecs[1] = '{1'b1, 0, 3, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, 0, 3, 2'b01};
        vecs[2] = '{1'b1, 6, 2, 1'b0, 1'b0, 1'b1, 1'b1, 5, -1, 6, 2, 2'b00};
        vecs[3] = '{1'b0, 4, 31, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, 4, 31, 2'b00};
        vecs[4] = '{1'b1, 0, 31, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 0, 31, 2'b01};

        load_cfg(vecs[0]);
        rst = 1'b1; start = 1'b0; abort = 1'b0; target = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_tap", tap_o, 0);
        chk("rst_ld", ld, 0);
        chk("rst_ce", ce, 0);
        chk("rst_inc", inc, 1);
        chk("rst_wl", wl, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            string tag;
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            load_cfg(v);
            ref_model(v.tgt);
            do_run(v.tgt, -1, lat);
            check_result(tag, lat);
            chk({tag, "_tap0"}, tap_o[0 +: TAP_BITS], v.etap0);
            chk({tag, "_tap1"}, tap_o[TAP_BITS +: TAP_BITS], v.etap1);
            chk({tag, "_fail"}, fail, v.efail);
            repeat (3) @(posedge clk);
            #1;
            chk({tag, "_hold_tap"}, tap_o, {v.etap1[TAP_BITS-1:0], v.etap0[TAP_BITS-1:0]});
        end

        // Randomized runs against the reference model
        for (int r = 0; r < 8; r++) begin
            bit tgt = 1'($urandom_range(0, 1));
            string tag = $sformatf("rnd%0d", r);
            for (int n = 0; n < LANES; n++) begin
                if ($urandom_range(0, 3) != 0) begin
                    cfg_bef[n] = ~tgt;
                    cfg_aft[n] = tgt;
                end else begin
                    cfg_bef[n] = 1'($urandom_range(0, 1));
                    cfg_aft[n] = 1'($urandom_range(0, 1));
                end
                cfg_edge[n] = int'($urandom_range(0, MAXTAP));
                cfg_tog[n]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXTAP)) : -1;
            end
            ref_model(tgt);
            do_run(tgt, -1, lat);
            check_result(tag, lat);
            for (int n = 0; n < LANES; n++) begin
                chk($sformatf("%s_tap%0d", tag, n), tap_o[n*TAP_BITS +: TAP_BITS], exp_tap[n]);
                chk($sformatf("%s_fail%0d", tag, n), fail[n], exp_fail[n]);
            end
        end

        // Abort in the 3rd SETTLE cycle at tap 2
        cfg_edge[0] = 20; cfg_edge[1] = 25;
        cfg_bef[0] = 1'b0; cfg_bef[1] = 1'b0;
        cfg_aft[0] = 1'b1; cfg_aft[1] = 1'b1;
        cfg_tog[0] = -1;   cfg_tog[1] = -1;
        snap();
        target = 1'b1;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1 + 2 * (SETTLE + SAMPLES + 2) + 2) @(posedge clk);
        #1;
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wl", wl, 0);
        chk("abort_ce0", ce_cnt[0] - base_ce[0], 2);
        chk("abort_ce1", ce_cnt[1] - base_ce[1], 2);
        repeat (60) @(posedge clk);
        #1;
        chk("abort_quiet_ld", ld_cnt - base_ld, 1);
        chk("abort_quiet_ce", ce_cnt[0] + ce_cnt[1] - base_ce[0] - base_ce[1], 4);
        chk("abort_idle_busy", busy, 0);
        ref_model(1'b1);
        do_run(1'b1, -1, lat);
        check_result("rerun", lat);
        chk("rerun_tap", tap_o, {5'd25, 5'd20});

        // Start while busy is ignored
        cfg_edge[0] = 3; cfg_edge[1] = 5;
        ref_model(1'b1);
        do_run(1'b1, 40, lat);
        check_result("busy_start", lat);
        chk("busy_start_tap", tap_o, {5'd5, 5'd3});

        // Reset during SAMPLE
        snap();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1 + SETTLE + 3) @(posedge clk);
        #1;
        chk("midrst_pre_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_tap", tap_o, 0);
        chk("midrst_fail", fail, 0);
        chk("midrst_ld", ld, 0);
        chk("midrst_ce", ce, 0);
        chk("midrst_inc", inc, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_quiet_ld", ld_cnt - base_ld, 1);
        chk("midrst_quiet_ce", ce_cnt[0] + ce_cnt[1] - base_ce[0] - base_ce[1], 0);

        // Start and abort together from DONE: abort wins
        do_run(1'b1, -1, lat);
        check_result("pre_sa", lat);
        snap();
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_done", done, 0);
        chk("sa_tap", tap_o, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("sa_ld", ld_cnt - base_ld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sddr_phy_leveler.md
Name: sddr_phy_leveler

Overview:
- Multi-lane delay-tap calibration sequencer for the DDR3 PHY. It replaces the single shared "increment while both sampled bits are low" delay control with a per-byte-lane search.
- Drives the IDELAYE2 LD/CE/INC controls of each lane and samples a per-lane feedback bit after each tap step. For every lane it records the first tap at which the feedback settles to a target level after having been seen at the opposite level.
- Sits between the controller's init/calibration sequencer and the PHY I/O delay primitives. Used for write leveling (target 1) and read-gate/DQS-edge search (target 0).

Parameters:
- LANES, 2, number of byte lanes (DATA_BITS/8).
- TAP_BITS, 5, width of the delay tap count; the maximum tap is 2^TAP_BITS-1.
- SETTLE_CYCLES, 16, cycles waited after a tap load/step before sampling; must be at least 1.
- SAMPLES, 8, consecutive sample cycles per tap; must be at least 1.

Ports:
- in_ddr_clock_i  input  1  DDR controller clock; everything is synchronous to its rising edge.
- in_phy_reset_i  input  1  synchronous, active-high reset.
- ctl_level_start_i  input  1  one-cycle start request; honoured only in IDLE or DONE.
- ctl_level_abort_i  input  1  returns the block to IDLE from any state.
- ctl_level_target_i  input  1  target feedback level; latched at start.
- ctl_level_busy_o  output  1  high in LOAD/SETTLE/SAMPLE/EVAL/STEP.
- ctl_level_done_o  output  1  high only in DONE.
- ctl_level_fail_o  output  LANES  per-lane "no edge found"; valid while done.
- ctl_level_tap_o  output  LANES*TAP_BITS  per-lane locked tap; lane n occupies bits [n*TAP_BITS +: TAP_BITS].
- ctl_write_level_o  output  1  equal to busy; puts the PHY DQ/DQS into leveling mode.
- phy_level_sample_i  input  LANES  per-lane feedback bit (already synchronised).
- phy_delay_ld_o  output  1  one-cycle pulse that loads tap 0 into every lane delay.
- phy_delay_ce_o  output  LANES  one-cycle per-lane increment enable.
- phy_delay_inc_o  output  1  constant 1.

Behaviour:
- Reset: the FSM enters IDLE. All outputs are 0 except phy_delay_inc_o, which is 1. Tap registers, fail bits and the internal tap counter are cleared.
- States and transitions:
  - IDLE/DONE: on start, latch target, clear all lane locked/seen/fail bits, clear tap outputs, and go to LOAD.
  - LOAD: assert phy_delay_ld_o for exactly one cycle; set the shared tap counter to 0; go to SETTLE.
  - SETTLE: stay exactly SETTLE_CYCLES cycles; go to SAMPLE.
  - SAMPLE: stay exactly SAMPLES cycles. Per lane, keep running AND (all_ones) and AND-of-inverse (all_zeros) of phy_level_sample_i. Accumulators restart at the first SAMPLE cycle. Go to EVAL.
  - EVAL (one cycle), for each unresolved lane:
    - Stable-target (all ones when target=1, all zeros when target=0) with seen set: set locked and capture tap_o = the current tap.
    - Stable-opposite: set seen.
    - Mixed samples: no change.
    - Stable-target with seen clear: no change. The lane starts in-window and must pass through the opposite level first.
  - After EVAL:
    - If every lane is locked or failed, go to DONE.
    - Else if tap == 2^TAP_BITS-1, set fail on every unlocked lane and go to DONE.
    - Else go to STEP.
  - STEP (one cycle): phy_delay_ce_o[n] = 1 for every lane not locked; tap counter +1; go to SETTLE. Locked lanes never receive CE again in this run.
- Tap counter is TAP_BITS wide and never wraps. The maximum-tap check precedes STEP.
- Lane evaluation in the same EVAL cycle that hits the maximum tap is applied before the fail check. A lane locking at the max tap is not failed.
- Tap/fail outputs hold their values in DONE and IDLE until the next start.
- Abort from any state: next cycle IDLE. Busy, done and CE drop to 0. Fail bits and taps are cleared.
- Start while busy is ignored. Start and abort in the same cycle: abort wins.
- Reset mid-run behaves like abort plus full clear; no further LD/CE pulses are issued.
- Cycles from start to the first SAMPLE = 1 (LOAD) + SETTLE_CYCLES. Each further tap costs 1 (STEP) + SETTLE_CYCLES + SAMPLES + 1 (EVAL).

Test Plan:
- LANES=2, target=1. Lane0 feedback is 0 for taps 0-6 and 1 from tap 7; lane1 is 0 up to tap 11, then 1 -> lane0 gets no CE after tap 7; tap_o = {12,7}; fail=00; done asserted; total CE pulses: lane0 7, lane1 12.
- target=1, lane0 reads 1 at all taps, lane1 edge at tap 3 -> lane0 steps to 31, fail=01, tap0=0, tap1=3; done after the tap-31 EVAL.
- Lane0 toggles every cycle during SAMPLE at tap 5 and is stable 1 from tap 6 (stable 0 at taps 0-4) -> tap 5 is ignored, tap0=6.
- target=0: lanes start at 1 and fall to 0 at taps 4 and 31 -> tap_o = {31,4}; fail=00 (a lock at the max tap does not fail).
- Abort asserted in the 3rd SETTLE cycle at tap 2 -> next cycle IDLE, busy=0, done=0, no further CE/LD. A subsequent start pulses LD exactly once and re-searches from tap 0.
- Reset asserted during SAMPLE, and start asserted during busy -> reset clears all outputs within 1 cycle; start while busy leaves the state/tap sequence unchanged.
